// File: rtl/excp_ctrl_if.sv
// Commit bus from the retire stage into excp_ctrl, plus the CSR write payload,
// flush and fetch redirect that excp_ctrl returns.
interface excp_ctrl_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_excp;
    logic [14:0] commit_code;
    logic        commit_badv_valid;
    logic [31:0] commit_badv;
    logic        commit_ertn;

    logic        excp_we;
    logic [1:0]  wr_crmd_plv;
    logic        wr_crmd_ie;
    logic        wr_crmd_da;
    logic        wr_crmd_pg;
    logic [1:0]  wr_prmd_pplv;
    logic        wr_prmd_pie;
    logic [14:0] wr_code;
    logic [31:0] wr_era;
    logic [31:0] wr_badv;
    logic [18:0] wr_vppn;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output commit_valid, commit_pc, commit_excp, commit_code,
        output commit_badv_valid, commit_badv, commit_ertn,
        input  excp_we, wr_crmd_plv, wr_crmd_ie, wr_crmd_da, wr_crmd_pg,
        input  wr_prmd_pplv, wr_prmd_pie, wr_code, wr_era, wr_badv, wr_vppn,
        input  flush, redirect_valid, redirect_pc
    );

    modport slave (
        input  commit_valid, commit_pc, commit_excp, commit_code,
        input  commit_badv_valid, commit_badv, commit_ertn,
        output excp_we, wr_crmd_plv, wr_crmd_ie, wr_crmd_da, wr_crmd_pg,
        output wr_prmd_pplv, wr_prmd_pie, wr_code, wr_era, wr_badv, wr_vppn,
        output flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/excp_ctrl.sv
// Exception/interrupt controller: collects interrupt status, arbitrates retiring
// traps and ertn, issues the CSR update, fetch redirect and a timed pipeline flush.
module excp_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  swi,
    input  logic [1:0]  swi_clr,
    input  logic        ti,
    input  logic        ti_clr,
    input  logic [7:0]  hwi,
    input  logic        ipi,
    output logic [12:0] is,
    input  logic [1:0]  crmd_plv,
    input  logic        crmd_ie,
    input  logic        crmd_da,
    input  logic        crmd_pg,
    input  logic [12:0] ecfg_lie,
    input  logic [31:0] eentry,
    input  logic [31:0] tlbrentry,
    input  logic [31:0] era_cur,
    excp_ctrl_if.slave  bus
);
    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    localparam logic [3:0] CntInit = 4'(FLUSH_CYCLES - 1);

    logic [1:0] swi_q;
    logic       ti_q, ipi_q;
    logic [7:0] hwi_s1_q, hwi_s2_q;
    logic       int_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swi_q    <= '0;
            ti_q     <= 1'b0;
            ipi_q    <= 1'b0;
            hwi_s1_q <= '0;
            hwi_s2_q <= '0;
        end else begin
            // swi wins over its clear; ti_clr wins over ti
            swi_q    <= swi | (swi_q & ~swi_clr);
            ti_q     <= ti_clr ? 1'b0 : (ti | ti_q);
            ipi_q    <= ipi;
            hwi_s1_q <= hwi;
            hwi_s2_q <= hwi_s1_q;
        end
    end

    assign is      = {ipi_q, ti_q, 1'b0, hwi_s2_q, swi_q};
    assign int_req = (|(is & ecfg_lie)) && crmd_ie;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d, flush_q, flush_d, rv_q, rv_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  plv_q, plv_d, pplv_q, pplv_d;
    logic        ie_q, ie_d, da_q, da_d, pg_q, pg_d, pie_q, pie_d;
    logic [14:0] code_q, code_d;
    logic [31:0] era_q, era_d, badv_q, badv_d;
    logic [18:0] vppn_q, vppn_d;
    logic        tlbr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        flush_d = 1'b0;
        rv_d    = 1'b0;
        pc_d    = pc_q;
        plv_d   = plv_q;
        ie_d    = ie_q;
        da_d    = da_q;
        pg_d    = pg_q;
        pplv_d  = pplv_q;
        pie_d   = pie_q;
        code_d  = code_q;
        era_d   = era_q;
        badv_d  = badv_q;
        vppn_d  = vppn_q;
        tlbr    = !int_req && (bus.commit_code[5:0] == 6'h3f);
        unique case (state_q)
            StIdle: begin
                if (bus.commit_valid && (int_req || bus.commit_excp || bus.commit_ertn)) begin
                    state_d = StFlush;
                    cnt_d   = CntInit;
                    flush_d = 1'b1;
                    rv_d    = 1'b1;
                    if (int_req || bus.commit_excp) begin
                        we_d   = 1'b1;
                        pplv_d = crmd_plv;
                        pie_d  = crmd_ie;
                        plv_d  = 2'b00;
                        ie_d   = 1'b0;
                        da_d   = tlbr ? 1'b1 : crmd_da;
                        pg_d   = tlbr ? 1'b0 : crmd_pg;
                        era_d  = bus.commit_pc;
                        code_d = int_req ? 15'h0000 : bus.commit_code;
                        vppn_d = bus.commit_badv[31:13];
                        pc_d   = tlbr ? tlbrentry : eentry;
                        if (bus.commit_badv_valid) begin
                            badv_d = bus.commit_badv;
                        end
                    end else begin
                        pc_d = era_cur;
                    end
                end
            end
            StFlush: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            flush_q <= 1'b0;
            rv_q    <= 1'b0;
            pc_q    <= '0;
            plv_q   <= '0;
            ie_q    <= 1'b0;
            da_q    <= 1'b0;
            pg_q    <= 1'b0;
            pplv_q  <= '0;
            pie_q   <= 1'b0;
            code_q  <= '0;
            era_q   <= '0;
            badv_q  <= '0;
            vppn_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            flush_q <= flush_d;
            rv_q    <= rv_d;
            pc_q    <= pc_d;
            plv_q   <= plv_d;
            ie_q    <= ie_d;
            da_q    <= da_d;
            pg_q    <= pg_d;
            pplv_q  <= pplv_d;
            pie_q   <= pie_d;
            code_q  <= code_d;
            era_q   <= era_d;
            badv_q  <= badv_d;
            vppn_q  <= vppn_d;
        end
    end

    assign bus.excp_we        = we_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = pc_q;
    assign bus.wr_crmd_plv    = plv_q;
    assign bus.wr_crmd_ie     = ie_q;
    assign bus.wr_crmd_da     = da_q;
    assign bus.wr_crmd_pg     = pg_q;
    assign bus.wr_prmd_pplv   = pplv_q;
    assign bus.wr_prmd_pie    = pie_q;
    assign bus.wr_code        = code_q;
    assign bus.wr_era         = era_q;
    assign bus.wr_badv        = badv_q;
    assign bus.wr_vppn        = vppn_q;
endmodule

// File: tb/tb_excp_ctrl.sv
// Randomized plus directed bench for excp_ctrl against a cycle-level behavioural model.
module tb_excp_ctrl;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  swi = '0, swi_clr = '0;
    logic        ti = 1'b0, ti_clr = 1'b0, ipi = 1'b0;
    logic [7:0]  hwi = '0;
    logic [12:0] is;
    logic [1:0]  crmd_plv = '0;
    logic        crmd_ie = 1'b0, crmd_da = 1'b0, crmd_pg = 1'b0;
    logic [12:0] ecfg_lie = '0;
    logic [31:0] eentry = 32'h1c008000;
    logic [31:0] tlbrentry = 32'h1c00f000;
    logic [31:0] era_cur = 32'h0;

    excp_ctrl_if bus ();

    excp_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .swi       (swi),
        .swi_clr   (swi_clr),
        .ti        (ti),
        .ti_clr    (ti_clr),
        .hwi       (hwi),
        .ipi       (ipi),
        .is        (is),
        .crmd_plv  (crmd_plv),
        .crmd_ie   (crmd_ie),
        .crmd_da   (crmd_da),
        .crmd_pg   (crmd_pg),
        .ecfg_lie  (ecfg_lie),
        .eentry    (eentry),
        .tlbrentry (tlbrentry),
        .era_cur   (era_cur),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [1:0]  m_swi;
    logic        m_ti, m_ipi;
    logic [7:0]  m_hwi;
    logic [7:0]  hq[$];
    int          m_rem;
    logic        e_we, e_flush, e_rv;
    logic [31:0] e_pc, e_era, e_badv;
    logic [1:0]  e_plv, e_pplv;
    logic        e_ie, e_da, e_pg, e_pie;
    logic [14:0] e_code;
    logic [18:0] e_vppn;

    function automatic logic [12:0] m_is();
        return {m_ipi, m_ti, 1'b0, m_hwi, m_swi};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_swi = '0; m_ti = 1'b0; m_ipi = 1'b0; m_hwi = '0;
        hq = {};
        hq.push_back(8'h00);
        m_rem = 0;
        e_we = 1'b0; e_flush = 1'b0; e_rv = 1'b0;
        e_pc = '0; e_era = '0; e_badv = '0; e_plv = '0; e_pplv = '0;
        e_ie = 1'b0; e_da = 1'b0; e_pg = 1'b0; e_pie = 1'b0;
        e_code = '0; e_vppn = '0;
    endtask

    // Advance the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        logic ireq;
        logic tlbr;
        if (!rst_n) begin
            m_reset();
            return;
        end
        ireq = (|(m_is() & ecfg_lie)) && crmd_ie;
        for (int i = 0; i < 2; i++)
            m_swi[i] = swi[i] ? 1'b1 : (swi_clr[i] ? 1'b0 : m_swi[i]);
        m_ti  = ti_clr ? 1'b0 : (ti ? 1'b1 : m_ti);
        m_ipi = ipi;
        hq.push_back(hwi);
        m_hwi = hq.pop_front();
        e_we = 1'b0;
        e_rv = 1'b0;
        if (m_rem > 0) begin
            m_rem--;
            e_flush = (m_rem > 0);
        end else if (bus.commit_valid && (ireq || bus.commit_excp || bus.commit_ertn)) begin
            m_rem   = FC;
            e_flush = 1'b1;
            e_rv    = 1'b1;
            if (ireq || bus.commit_excp) begin
                e_we   = 1'b1;
                e_code = ireq ? 15'h0 : bus.commit_code;
                tlbr   = !ireq && (bus.commit_code[5:0] == 6'h3f);
                e_pplv = crmd_plv;
                e_pie  = crmd_ie;
                e_plv  = 2'b00;
                e_ie   = 1'b0;
                e_da   = tlbr ? 1'b1 : crmd_da;
                e_pg   = tlbr ? 1'b0 : crmd_pg;
                e_era  = bus.commit_pc;
                e_vppn = bus.commit_badv[31:13];
                e_pc   = tlbr ? tlbrentry : eentry;
                if (bus.commit_badv_valid) e_badv = bus.commit_badv;
            end else begin
                e_pc = era_cur;
            end
        end else begin
            e_flush = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("is", 32'(is), 32'(m_is()));
        check("excp_we", 32'(bus.excp_we), 32'(e_we));
        check("flush", 32'(bus.flush), 32'(e_flush));
        check("redirect_valid", 32'(bus.redirect_valid), 32'(e_rv));
        check("redirect_pc", bus.redirect_pc, e_pc);
        check("wr_crmd", 32'({bus.wr_crmd_plv, bus.wr_crmd_ie, bus.wr_crmd_da, bus.wr_crmd_pg}),
              32'({e_plv, e_ie, e_da, e_pg}));
        check("wr_prmd", 32'({bus.wr_prmd_pplv, bus.wr_prmd_pie}), 32'({e_pplv, e_pie}));
        check("wr_code", 32'(bus.wr_code), 32'(e_code));
        check("wr_era", bus.wr_era, e_era);
        check("wr_badv", bus.wr_badv, e_badv);
        check("wr_vppn", 32'(bus.wr_vppn), 32'(e_vppn));
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        swi = '0; swi_clr = '0; ti = 1'b0; ti_clr = 1'b0; ipi = 1'b0; hwi = '0;
        ecfg_lie = '0; crmd_ie = 1'b0;
        bus.commit_valid = 1'b0; bus.commit_excp = 1'b0; bus.commit_ertn = 1'b0;
        bus.commit_badv_valid = 1'b0;
    endtask

    initial begin
        bus.commit_pc = '0; bus.commit_code = '0; bus.commit_badv = '0;
        idle_inputs();
        m_reset();
        #3;
        compare_all();
        check("reset_is", 32'(is), 32'h0);
        check("reset_flush", 32'(bus.flush), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Software interrupt set then clear
        swi = 2'b01; tick();
        check("swi_set", 32'(is[0]), 32'h1);
        swi = 2'b00; swi_clr = 2'b01; tick();
        check("swi_clr", 32'(is[0]), 32'h0);
        swi = 2'b11; swi_clr = 2'b11; tick();
        check("swi_set_wins", 32'(is[1:0]), 32'h3);
        swi = 2'b00; tick();
        idle_inputs();
        swi_clr = 2'b11; tick();
        swi_clr = 2'b00;

        // Timer interrupt: clear wins, then set and clear
        ti = 1'b1; ti_clr = 1'b1; tick();
        check("ti_clr_wins", 32'(is[11]), 32'h0);
        ti_clr = 1'b0; tick();
        check("ti_set", 32'(is[11]), 32'h1);
        ti = 1'b0; ti_clr = 1'b1; tick();
        check("ti_clear", 32'(is[11]), 32'h0);
        ti_clr = 1'b0;

        // Hardware interrupt through the synchronizer, then taken on a commit
        hwi = 8'h08; ecfg_lie = 13'h0020; crmd_ie = 1'b1; tick();
        check("hwi_lat1", 32'(is[5]), 32'h0);
        tick();
        check("hwi_lat2", 32'(is[5]), 32'h1);
        tick();
        check("no_commit_no_int", 32'(bus.excp_we), 32'h0);
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h1c000100; bus.commit_excp = 1'b1;
        bus.commit_code = 15'h0009; tick();
        check("int_we", 32'(bus.excp_we), 32'h1);
        check("int_code", 32'(bus.wr_code), 32'h0);
        check("int_era", bus.wr_era, 32'h1c000100);
        check("int_redirect", bus.redirect_pc, 32'h1c008000);
        idle_inputs(); tick(); tick(); tick(); tick();

        // TLB refill exception
        bus.commit_valid = 1'b1; bus.commit_excp = 1'b1; bus.commit_code = 15'h003f;
        bus.commit_badv_valid = 1'b1; bus.commit_badv = 32'h00402abc; bus.commit_pc = 32'h1c000140;
        crmd_plv = 2'd3; crmd_da = 1'b0; crmd_pg = 1'b1; tick();
        check("tlbr_da", 32'(bus.wr_crmd_da), 32'h1);
        check("tlbr_pg", 32'(bus.wr_crmd_pg), 32'h0);
        check("tlbr_pplv", 32'(bus.wr_prmd_pplv), 32'h3);
        check("tlbr_vppn", 32'(bus.wr_vppn), 32'h00201);
        check("tlbr_redirect", bus.redirect_pc, 32'h1c00f000);
        idle_inputs(); tick(); tick();

        // ertn with a commit arriving during the second flush cycle
        bus.commit_valid = 1'b1; bus.commit_ertn = 1'b1; era_cur = 32'h1c000200; tick();
        check("ertn_we", 32'(bus.excp_we), 32'h0);
        check("ertn_redirect", bus.redirect_pc, 32'h1c000200);
        check("ertn_flush1", 32'(bus.flush), 32'h1);
        bus.commit_ertn = 1'b0; bus.commit_excp = 1'b1; bus.commit_code = 15'h0004; tick();
        check("ertn_flush2", 32'(bus.flush), 32'h1);
        check("ertn_ignored", 32'(bus.excp_we), 32'h0);
        idle_inputs(); tick();
        check("ertn_flush_end", 32'(bus.flush), 32'h0);
        check("ertn_ignored2", 32'(bus.excp_we), 32'h0);

        // Reset in the middle of a flush
        bus.commit_valid = 1'b1; bus.commit_excp = 1'b1; bus.commit_code = 15'h0008; tick();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        m_reset();
        check("rst_flush", 32'(bus.flush), 32'h0);
        compare_all();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        bus.commit_valid = 1'b1; bus.commit_excp = 1'b1; bus.commit_code = 15'h0005;
        bus.commit_pc = 32'h1c000300; tick();
        check("post_rst_we", 32'(bus.excp_we), 32'h1);
        check("post_rst_era", bus.wr_era, 32'h1c000300);
        idle_inputs(); tick(); tick();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            swi      = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            swi_clr  = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            ti       = ($urandom_range(0, 15) == 0);
            ti_clr   = ($urandom_range(0, 7) == 0);
            ipi      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) hwi = 8'($urandom) & 8'($urandom);
            ecfg_lie = 13'($urandom);
            crmd_ie  = 1'($urandom);
            crmd_plv = 2'($urandom);
            crmd_da  = 1'($urandom);
            crmd_pg  = 1'($urandom);
            era_cur  = $urandom;
            bus.commit_valid      = 1'($urandom);
            bus.commit_pc         = $urandom;
            bus.commit_excp       = ($urandom_range(0, 3) == 0);
            bus.commit_ertn       = ($urandom_range(0, 3) == 0);
            bus.commit_code       = ($urandom_range(0, 3) == 0) ?
                                    {9'($urandom), 6'h3f} : 15'($urandom);
            bus.commit_badv_valid = 1'($urandom);
            bus.commit_badv       = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
